// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with private HI/LO registers.
// Optional flush input enabled by defining MDU_CANCEL_EN.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_phi;
  logic [WIDTH-1:0] r_plo;
  logic             r_pwe;

  logic w_cancel;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  logic w_unused_cancel;
  assign w_unused_cancel = cancel;
  assign w_cancel = 1'b0;
`endif

  logic w_mult, w_div, w_multu, w_divu;
  logic w_mfhi, w_mflo, w_mthi, w_mtlo;
  logic w_is_mul, w_is_div, w_md, w_idle;

  assign w_mult   = (op == 4'b0000);
  assign w_div    = (op == 4'b0001);
  assign w_multu  = (op == 4'b0010);
  assign w_divu   = (op == 4'b0011);
  assign w_mfhi   = (op == 4'b0100);
  assign w_mflo   = (op == 4'b0101);
  assign w_mthi   = (op == 4'b0110);
  assign w_mtlo   = (op == 4'b0111);
  assign w_is_mul = w_mult | w_multu;
  assign w_is_div = w_div | w_divu;
  assign w_md     = w_is_mul | w_is_div;
  assign w_idle   = (r_state == S_IDLE);

  assign busy = reset & ~w_cancel &
                ((start & w_md & w_idle) | ~w_idle);

  // Multiply: sign- or zero-extend to 2W, low 2W bits are exact.
  logic [2*WIDTH-1:0] w_ma, w_mb, w_prod;
  assign w_ma = {{WIDTH{w_mult & rs_val[WIDTH-1]}}, rs_val};
  assign w_mb = {{WIDTH{w_mult & rt_val[WIDTH-1]}}, rt_val};
  assign w_prod = w_ma * w_mb;

  // Divide on magnitudes, then restore signs.
  // Quotient truncates to zero; remainder follows the dividend.
  logic             w_aneg, w_bneg, w_dz;
  logic [WIDTH-1:0] w_aa, w_ab, w_dv;
  logic [WIDTH-1:0] w_uq, w_ur, w_q, w_r;
  assign w_aneg = w_div & rs_val[WIDTH-1];
  assign w_bneg = w_div & rt_val[WIDTH-1];
  assign w_aa   = w_aneg ? -rs_val : rs_val;
  assign w_ab   = w_bneg ? -rt_val : rt_val;
  assign w_dz   = (rt_val == '0);
  assign w_dv   = w_dz ? WIDTH'(1) : w_ab;
  assign w_uq   = w_aa / w_dv;
  assign w_ur   = w_aa % w_dv;
  assign w_q    = (w_aneg ^ w_bneg) ? -w_uq : w_uq;
  assign w_r    = w_aneg ? -w_ur : w_ur;

  logic [WIDTH-1:0] w_nhi, w_nlo;
  logic             w_nwe;
  assign w_nhi = w_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_r;
  assign w_nlo = w_is_mul ? w_prod[WIDTH-1:0] : w_q;
  assign w_nwe = w_is_mul | ~w_dz;

  // Issue, countdown, commit and mthi/mtlo writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pwe   <= 1'b0;
    end else if (w_cancel) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pwe   <= 1'b0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - ONE;
      if (r_cnt == ONE) begin
        r_state <= S_IDLE;
        r_pwe   <= 1'b0;
        if (r_pwe) begin
          r_hi <= r_phi;
          r_lo <= r_plo;
        end
      end
    end else if (start) begin
      if (w_md) begin
        r_state <= S_BUSY;
        r_cnt   <= w_is_mul ? MULT_N : DIV_N;
        r_phi   <= w_nhi;
        r_plo   <= w_nlo;
        r_pwe   <= w_nwe;
      end else if (w_mthi) begin
        r_hi <= rs_val;
      end else if (w_mtlo) begin
        r_lo <= rs_val;
      end
    end
  end

  // mfhi/mflo read port, zero for every other op.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      w_mfhi:  rd_data = r_hi;
      w_mflo:  rd_data = r_lo;
      default: rd_data = '0;
    endcase
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plan steps plus random ops against a
// cycle-indexed reference model of md_unit.
module tb_md_unit;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  op     = 4'b1000;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic [31:0] rd_data, hi, lo;

  int n_chk = 0;
  int n_err = 0;

`ifdef MDU_CANCEL_EN
  localparam bit CAN = 1'b1;
`else
  localparam bit CAN = 1'b0;
`endif

  bit [31:0] m_hi = '0;
  bit [31:0] m_lo = '0;
  bit [31:0] m_phi, m_plo;
  bit        m_pv;
  int        m_end = -1;
  int        cyc = 0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .cancel  (cancel),
    .busy    (busy),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input bit [3:0] o,
                          input bit [31:0] a,
                          input bit [31:0] b);
    longint    sp;
    bit [63:0] up;
    int        sa, sb;
    sa = a;
    sb = b;
    m_pv = 1'b1;
    case (o)
      4'd0: begin
        sp = longint'(sa) * longint'(sb);
        {m_phi, m_plo} = sp;
      end
      4'd2: begin
        up = {32'd0, a} * {32'd0, b};
        {m_phi, m_plo} = up;
      end
      4'd1: begin
        if (b == 0) m_pv = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_plo = a;
          m_phi = 0;
        end else begin
          m_plo = sa / sb;
          m_phi = sa % sb;
        end
      end
      default: begin
        if (b == 0) m_pv = 1'b0;
        else begin
          m_plo = a / b;
          m_phi = a % b;
        end
      end
    endcase
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model.
  task automatic step(input bit st, input bit [3:0] o,
                      input bit [31:0] a, input bit [31:0] b,
                      input bit cn);
    bit        inflt, md, eb;
    bit [31:0] erd;
    start  = st;
    op     = o;
    rs_val = a;
    rt_val = b;
    cancel = cn;
    inflt  = (m_end >= cyc);
    md     = (o <= 4'd3);
    eb     = (inflt | (st & md)) & !(CAN & cn);
    erd    = (o == 4'd4) ? m_hi : (o == 4'd5) ? m_lo : 32'd0;
    @(negedge clk);
    chk("busy", {31'd0, busy}, {31'd0, eb});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("rd_data", rd_data, erd);
    @(posedge clk);
    if (CAN && cn) begin
      m_end = -1;
    end else if (inflt) begin
      if (cyc == m_end && m_pv) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      if (md) begin
        model_op(o, a, b);
        m_end = cyc + ((o == 4'd0 || o == 4'd2) ? 5 : 10);
      end else if (o == 4'd6) begin
        m_hi = a;
      end else if (o == 4'd7) begin
        m_lo = a;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'b1000, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic bit [31:0] pickv();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit [3:0] ro;
    int       r;

    // Reset state
    #2;
    op = 4'd4;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    start = 1'b1;
    op    = 4'd0;
    #1;
    chk("rst_busy_start", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    op    = 4'b1000;
    @(posedge clk);
    #1;

    // mult 0xFFFFFFFE x 3
    step(1'b1, 4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(5);
    chk("p1_busy", {31'd0, busy}, 32'd0);
    chk("p1_hi", hi, 32'hFFFF_FFFF);
    chk("p1_lo", lo, 32'hFFFF_FFFA);

    // divu 7/2, div -7/2
    step(1'b1, 4'd3, 32'd7, 32'd2, 1'b0);
    idle(10);
    chk("p2_divu_hi", hi, 32'd1);
    chk("p2_divu_lo", lo, 32'd3);
    step(1'b1, 4'd1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(10);
    chk("p2_div_hi", hi, 32'hFFFF_FFFF);
    chk("p2_div_lo", lo, 32'hFFFF_FFFD);

    // Divide by zero and signed overflow
    step(1'b1, 4'd6, 32'h11, 32'd0, 1'b0);
    step(1'b1, 4'd7, 32'h22, 32'd0, 1'b0);
    step(1'b1, 4'd1, 32'd5, 32'd0, 1'b0);
    idle(10);
    chk("p3_dz_busy", {31'd0, busy}, 32'd0);
    chk("p3_dz_hi", hi, 32'h11);
    chk("p3_dz_lo", lo, 32'h22);
    step(1'b1, 4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(10);
    chk("p3_ovf_hi", hi, 32'd0);
    chk("p3_ovf_lo", lo, 32'h8000_0000);

    // mtlo then mflo; op issued while busy is ignored
    step(1'b1, 4'd7, 32'hABCD, 32'd0, 1'b0);
    start = 1'b1;
    op    = 4'd5;
    #1;
    chk("p4_mflo", rd_data, 32'hABCD);
    step(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
    step(1'b1, 4'd2, 32'd6, 32'd7, 1'b0);
    step(1'b1, 4'd0, 32'd100, 32'd100, 1'b0);
    idle(4);
    chk("p4_ign_hi", hi, 32'd0);
    chk("p4_ign_lo", lo, 32'd42);

    // Reset in cycle 3 of a mult
    step(1'b1, 4'd6, 32'h55, 32'd0, 1'b0);
    step(1'b1, 4'd0, 32'd3, 32'd4, 1'b0);
    idle(2);
    start = 1'b0;
    op    = 4'b1000;
    reset = 1'b0;
    #1;
    chk("p5_busy", {31'd0, busy}, 32'd0);
    chk("p5_hi", hi, 32'd0);
    chk("p5_lo", lo, 32'd0);
    m_hi  = '0;
    m_lo  = '0;
    m_end = -1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    step(1'b1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(5);
    chk("p5_after_hi", hi, 32'd0);
    chk("p5_after_lo", lo, 32'd1);

    // Cancel in cycle 2 of a mult
    step(1'b1, 4'd6, 32'h99, 32'd0, 1'b0);
    step(1'b1, 4'd0, 32'd2, 32'd3, 1'b0);
    step(1'b0, 4'b1000, 32'd0, 32'd0, 1'b0);
    start  = 1'b0;
    op     = 4'b1000;
    cancel = 1'b1;
    #1;
    chk("p6_busy_c2", {31'd0, busy}, CAN ? 32'd0 : 32'd1);
    step(1'b0, 4'b1000, 32'd0, 32'd0, 1'b1);
    idle(3);
    chk("p6_busy_c6", {31'd0, busy}, 32'd0);
    chk("p6_hi", hi, CAN ? 32'h99 : 32'd0);
    chk("p6_lo", lo, CAN ? 32'd1 : 32'd6);

    // Random traffic
    repeat (400) begin
      r  = $urandom_range(0, 11);
      ro = (r < 10) ? 4'(r) : 4'($urandom_range(10, 15));
      step(($urandom_range(0, 3) != 0), ro, pickv(), pickv(),
           ($urandom_range(0, 15) == 0));
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers.
- Sits in the EX stage of the pipelined MIPS core. It consumes the 4-bit HILO_type op code produced by the decoder, plus the forwarded rs/rt operands.
- Provides `busy` to the hazard unit and the mfhi/mflo read value to the E-stage result mux.
- Successor to the fixed 32-bit HILO path: datapath width and per-operation latency are parametrised, and division by zero is defined.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- MULT_CYCLES, 5, cycles from mult/multu issue until HI/LO are written (≥1).
- DIV_CYCLES, 10, cycles from div/divu issue until HI/LO are written (≥1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  op valid this cycle; qualified by the E stage not being stalled.
- op  input  4  0000 mult, 0001 div, 0010 multu, 0011 divu, 0100 mfhi, 0101 mflo, 0110 mthi, 0111 mtlo, 1000 none.
- rs_val  input  WIDTH  operand A / mthi-mtlo source.
- rt_val  input  WIDTH  operand B.
- cancel  input  1  abort in-flight op (only with the optional feature).
- busy  output  1  an md op is issuing or in flight.
- rd_data  output  WIDTH  mfhi→HI, mflo→LO, otherwise 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, active-low): HI=0, LO=0, counter=0, state IDLE, pending result registers=0. While reset is asserted, busy=0 and rd_data=0.
- States:
  - IDLE: counter==0.
  - BUSY: counter!=0.
- Issue:
  - An md op is start & op∈{0000..0011} while in IDLE.
  - On the issuing edge: latch the result into pending HI/LO, set counter to MULT_CYCLES or DIV_CYCLES, go to BUSY.
- Countdown:
  - Each edge in BUSY decrements the counter.
  - On the edge where counter==1, HI/LO take the pending values and the unit returns to IDLE.
- busy is combinational: (start & md op & IDLE) | BUSY.
  - For issue in cycle 0 with latency N, busy=1 in cycles 0..N.
  - New HI/LO and busy=0 are visible from cycle N+1.
- Arithmetic:
  - mult: signed WIDTH×WIDTH→2·WIDTH product; HI=upper half, LO=lower half.
  - multu: same, unsigned.
  - div: signed. LO=quotient truncated toward zero; HI=remainder, with the sign of the dividend.
  - divu: unsigned.
  - Signed overflow (−2^(WIDTH−1) / −1): LO=−2^(WIDTH−1), HI=0.
  - Divide by zero (rt_val==0): the op still occupies DIV_CYCLES; HI/LO are left unchanged at completion.
- mthi/mtlo:
  - With start in IDLE: HI (or LO) ← rs_val at the next edge; no busy.
- mfhi/mflo:
  - rd_data is combinational from the current HI/LO, so a value written at an edge is readable in the following cycle.
- start while BUSY:
  - Any op (md, mt, mf) is ignored for state; rd_data still reflects current HI/LO.
  - The hazard unit must stall any HILO-using op while busy; this block does not queue.
- start with op=1000, or any unlisted code: no effect.
- Reset asserted mid-operation: the in-flight op is discarded and all state returns to reset values immediately.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - cancel=1 at an edge forces counter to 0 and drops the pending result; HI/LO keep their pre-issue values.
  - cancel also blocks an issue, mthi or mtlo in that same cycle.
  - busy is masked to 0 in any cycle where cancel=1.
  - Used for a flush on exception.
- Undefined: the cancel port exists but is ignored; all ops run to completion.

Test Plan:
- mult 0xFFFFFFFE × 3 (WIDTH=32, MULT_CYCLES=5), start in cycle 0:
  - busy=1 cycles 0–5.
  - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- divu 7/2, then div −7/2, each DIV_CYCLES=10:
  - divu: LO=3, HI=1 at cycle 11.
  - div: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero:
  - Setup: mthi 0x11, mtlo 0x22, then div rs=5, rt=0.
  - busy for 11 cycles; HI=0x11, LO=0x22 afterwards.
  - Second case, div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- mtlo 0xABCD, then mflo in the next cycle → rd_data=0xABCD.
  - A mult issued while BUSY is ignored, and HI/LO reflect only the first op.
- Reset dropped low in cycle 3 of a mult → HI=LO=0 and busy=0 immediately; a later mult issue behaves normally.
- MDU_CANCEL_EN:
  - cancel in cycle 2 of a mult → busy=0 from cycle 2; HI/LO unchanged.
  - Without the macro: same stimulus completes normally at cycle 6.
